// File: rtl/pp_buf_pkg.sv
// Shared ping-pong buffer definitions: bank-state encoding and the bit-reverse helper.
package pp_buf_pkg;

  typedef enum logic [1:0] {
    BankEmpty    = 2'd0,
    BankFilling  = 2'd1,
    BankFull     = 2'd2,
    BankDraining = 2'd3
  } bank_state_e;

  // Reverses the low `width` bits of `value`; bits above `width` come back as zero.
  function automatic logic [31:0] bit_reverse(input logic [31:0] value, input int unsigned width);
    logic [31:0] src;
    logic [31:0] rev;
    src = value;
    rev = '0;
    for (int unsigned i = 0; i < 32; i++) begin
      if (i < width) begin
        rev = {rev[30:0], src[0]};
        src = src >> 1;
      end
    end
    return rev;
  endfunction

endpackage

// File: rtl/pp_frame_reader_if.sv
// Sample-in / sample-out handshake bundle of the frame reorder buffer, plus its status flags.
interface pp_frame_reader_if #(
  parameter int unsigned WIDTH = 8
);

  logic [WIDTH-1:0] data_in;
  logic             data_valid;
  logic             data_ready;
  logic [WIDTH-1:0] data_out;
  logic             out_valid;
  logic             out_ready;
  logic             out_last;
  logic             full;
  logic             empty;

  modport master (
    output data_in, data_valid, out_ready,
    input  data_ready, data_out, out_valid, out_last, full, empty
  );

  modport slave (
    input  data_in, data_valid, out_ready,
    output data_ready, data_out, out_valid, out_last, full, empty
  );

endinterface

// File: rtl/pp_bank_ram.sv
// Two-bank sample store addressed {bank, addr}: synchronous write, combinational read.
module pp_bank_ram #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned DEPTH      = 128,
  parameter int unsigned ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH:0]   waddr,
  input  logic [WIDTH-1:0]      wdata,
  input  logic [ADDR_WIDTH:0]   raddr,
  output logic [WIDTH-1:0]      rdata
);

  logic [WIDTH-1:0] mem [2*DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/pp_frame_reader.sv
// Ping-pong reorder buffer: fills one bank in natural order while draining the other.
// Define PP_FRAME_READER_BITREV_EN to drain in bit-reversed order; otherwise natural order.
module pp_frame_reader
  import pp_buf_pkg::*;
#(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned DEPTH      = 128,
  parameter int unsigned ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  pp_frame_reader_if.slave bus
);

  localparam logic [ADDR_WIDTH-1:0] AddrLast = ADDR_WIDTH'(DEPTH - 1);

  bank_state_e           state_q [2];
  bank_state_e           state_d [2];
  logic                  wr_bank_q, wr_bank_d;
  logic                  rd_bank_q, rd_bank_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
  logic [ADDR_WIDTH-1:0] raddr;
  logic [WIDTH-1:0]      data_out_q, data_out_d;
  logic [WIDTH-1:0]      ram_rdata;
  logic                  out_valid_q, out_valid_d;
  logic                  out_last_q, out_last_d;
  logic                  data_ready_q, data_ready_d;
  logic                  wr_fire, fetch, wr_last, rd_last;

  always_comb begin
`ifdef PP_FRAME_READER_BITREV_EN
    raddr = ADDR_WIDTH'(bit_reverse(32'(rd_addr_q), ADDR_WIDTH));
`else
    raddr = rd_addr_q;
`endif
  end

  pp_bank_ram #(
    .WIDTH      (WIDTH),
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .clk   (clk),
    .we    (wr_fire),
    .waddr ({wr_bank_q, wr_addr_q}),
    .wdata (bus.data_in),
    .raddr ({rd_bank_q, raddr}),
    .rdata (ram_rdata)
  );

  always_comb begin
    state_d     = state_q;
    wr_bank_d   = wr_bank_q;
    rd_bank_d   = rd_bank_q;
    wr_addr_d   = wr_addr_q;
    rd_addr_d   = rd_addr_q;
    data_out_d  = data_out_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;

    wr_fire = bus.data_valid && data_ready_q;
    fetch   = (state_q[rd_bank_q] inside {BankFull, BankDraining}) &&
              (!out_valid_q || bus.out_ready);
    wr_last = (wr_addr_q == AddrLast);
    rd_last = (rd_addr_q == AddrLast);

    // data_ready_q guarantees the write bank is never the bank being fetched from.
    if (wr_fire) begin
      state_d[wr_bank_q] = wr_last ? BankFull : BankFilling;
      wr_addr_d          = wr_addr_q + 1'b1;
      if (wr_last) begin
        wr_bank_d = ~wr_bank_q;
      end
    end

    if (fetch) begin
      state_d[rd_bank_q] = rd_last ? BankEmpty : BankDraining;
      rd_addr_d          = rd_addr_q + 1'b1;
      data_out_d         = ram_rdata;
      out_last_d         = rd_last;
      out_valid_d        = 1'b1;
      if (rd_last) begin
        rd_bank_d = ~rd_bank_q;
      end
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
    end

    // Registered, so a bank freed this cycle is only advertised from the next cycle on.
    data_ready_d = state_d[wr_bank_d] inside {BankEmpty, BankFilling};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q[0]   <= BankEmpty;
      state_q[1]   <= BankEmpty;
      wr_bank_q    <= 1'b0;
      rd_bank_q    <= 1'b0;
      wr_addr_q    <= '0;
      rd_addr_q    <= '0;
      data_out_q   <= '0;
      out_valid_q  <= 1'b0;
      out_last_q   <= 1'b0;
      data_ready_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      wr_bank_q    <= wr_bank_d;
      rd_bank_q    <= rd_bank_d;
      wr_addr_q    <= wr_addr_d;
      rd_addr_q    <= rd_addr_d;
      data_out_q   <= data_out_d;
      out_valid_q  <= out_valid_d;
      out_last_q   <= out_last_d;
      data_ready_q <= data_ready_d;
    end
  end

  assign bus.data_out   = data_out_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_last   = out_last_q;
  assign bus.data_ready = data_ready_q;
  assign bus.full       = (state_q[0] inside {BankFull, BankDraining}) &&
                          (state_q[1] inside {BankFull, BankDraining});
  assign bus.empty      = (state_q[0] == BankEmpty) && (state_q[1] == BankEmpty) &&
                          !out_valid_q;

endmodule
